// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: instruction fetch front-end with a small prefetch FIFO.
//
// Owns the fetch PC and issues one word read per cycle to a synchronous
// instruction memory whenever the FIFO has guaranteed room for the reply.
// Returned words are queued together with their PC+4 and handed to decode
// through a valid/ready handshake. A redirect from the branch unit flushes
// the queue, discards any in-flight reply and restarts fetch at the target.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   imem_req          read strobe to instruction memory
//   imem_addr         word address of the read (fetch_pc[ADDR_W+1:2])
//   imem_rdata        read data, valid the cycle after imem_req
//   redirect          taken branch; flushes and restarts fetch
//   redirect_pc       branch target byte address (low two bits ignored)
//   out_valid         head entry available to decode
//   out_ready         decode accepts the head entry
//   out_inst          head instruction
//   out_pc_plus_4     PC+4 of the head instruction
//   occupancy         number of valid FIFO entries

module inst_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         imem_req,
  output logic [ADDR_W-1:0]            imem_addr,
  input  logic [31:0]                  imem_rdata,
  input  logic                         redirect,
  input  logic [31:0]                  redirect_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_inst,
  output logic [31:0]                  out_pc_plus_4,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  // One extra bit so count + pending cannot wrap before the compare.
  localparam int unsigned CRD_W = CNT_W + 1;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc_plus_4;
  } entry_t;

  logic [31:0]      fetch_pc;
  logic             pending;
  logic [31:0]      pending_pc;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  entry_t           mem [DEPTH];

  logic             pop_c;
  logic             push_c;
  logic [CRD_W-1:0] credit_c;
  entry_t           head_c;

  // Handshake and credit check: a read is only issued when its reply is
  // guaranteed a slot, counting the reply already in flight.
  always_comb begin
    out_valid = (count != '0) & ~redirect;
    pop_c     = out_valid & out_ready;
    push_c    = pending & ~redirect;
    credit_c  = CRD_W'(count) + CRD_W'(pending) - CRD_W'(pop_c);
    imem_req  = ~rst & ~redirect & (credit_c < CRD_W'(DEPTH));
  end

  assign imem_addr = fetch_pc[ADDR_W+1:2];
  assign occupancy = count;

  // Head entry is presented continuously; meaningless while out_valid is low.
  assign head_c        = mem[rd_ptr];
  assign out_inst      = head_c.inst;
  assign out_pc_plus_4 = head_c.pc_plus_4;

  // Fetch PC, in-flight tracking and FIFO bookkeeping; redirect overrides all.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc   <= RESET_PC;
      pending    <= 1'b0;
      pending_pc <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else if (redirect) begin
      fetch_pc   <= {redirect_pc[31:2], 2'b00};
      pending    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      if (imem_req) begin
        pending    <= 1'b1;
        pending_pc <= fetch_pc;
        fetch_pc   <= fetch_pc + 32'd4;
      end else begin
        pending    <= 1'b0;
      end
      if (push_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  // Entry storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= '{inst: imem_rdata, pc_plus_4: pending_pc + 32'd4};
    end
  end

  // The credit rule must make an overflowing push impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    push_c |-> ((count < CNT_W'(DEPTH)) || pop_c));

  // Lower target bits are word-alignment noise from the branch adder.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: a queue-based reference model is
// advanced once per clock and every output is compared against it; literal
// expectations on the observed request/delivery streams pin the model.

module tb_inst_fetch_queue;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 6;

  logic              clk;
  logic              rst;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_inst;
  logic [31:0]       out_pc_plus_4;
  logic [2:0]        occupancy;

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc_plus_4(out_pc_plus_4),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory: word at address a holds the value a.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= 32'(imem_addr);
  end

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
  } ent_t;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  ent_t        mq[$];
  logic [31:0] m_pc;
  logic        m_pend;
  logic [31:0] m_ppc;

  // Observations from the most recent cycle
  ent_t        dlog[$];
  logic [31:0] rlog[$];
  logic        obs_valid;
  logic        obs_req;
  logic [31:0] obs_occ;
  logic [31:0] obs_addr;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] rl(input int i);
    return (rlog.size() > i) ? rlog[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] dl_inst(input int i);
    return (dlog.size() > i) ? dlog[i].inst : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] dl_pc4(input int i);
    return (dlog.size() > i) ? dlog[i].pc4 : 32'hDEAD_BEEF;
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_pc   = 32'h0;
    m_pend = 1'b0;
    m_ppc  = 32'h0;
  endfunction

  function automatic void clear_logs();
    dlog.delete();
    rlog.delete();
  endfunction

  // One clock: drive inputs at negedge, compare against the model, then
  // advance the model across the rising edge.
  task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc);
    int   sz;
    logic ev, ep, er;
    @(negedge clk);
    out_ready   = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    #1;
    sz = mq.size();
    ev = (sz != 0) && !redir;
    ep = ev && rdy;
    er = !redir && ((sz + int'(m_pend) - int'(ep)) < int'(DEPTH));
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("occupancy", 32'(occupancy), 32'(sz));
    chk("imem_req", 32'(imem_req), 32'(er));
    chk("imem_addr", 32'(imem_addr), 32'(m_pc[ADDR_W+1:2]));
    if (ev) begin
      chk("out_inst", out_inst, mq[0].inst);
      chk("out_pc_plus_4", out_pc_plus_4, mq[0].pc4);
    end
    obs_valid = out_valid;
    obs_req   = imem_req;
    obs_occ   = 32'(occupancy);
    obs_addr  = 32'(imem_addr);
    if (out_valid && out_ready) dlog.push_back('{inst: out_inst, pc4: out_pc_plus_4});
    if (imem_req) rlog.push_back(32'(imem_addr));
    @(posedge clk);
    if (redir) begin
      mq.delete();
      m_pend = 1'b0;
      m_pc   = {rpc[31:2], 2'b00};
    end else begin
      if (ep) void'(mq.pop_front());
      if (m_pend) mq.push_back('{inst: 32'(m_ppc[ADDR_W+1:2]), pc4: m_ppc + 32'd4});
      if (er) begin
        m_pend = 1'b1;
        m_ppc  = m_pc;
        m_pc   = m_pc + 32'd4;
      end else begin
        m_pend = 1'b0;
      end
    end
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset(output logic [31:0] pre_occ);
    #1;
    pre_occ = 32'(occupancy);
    rst = 1'b1;
    #1;
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  logic [31:0] pre;
  logic [31:0] pat;

  initial begin
    rst         = 1'b1;
    out_ready   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    imem_rdata  = 32'h0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("init_out_valid", 32'(out_valid), 32'd0);
    chk("init_occupancy", 32'(occupancy), 32'd0);
    chk("init_imem_req", 32'(imem_req), 32'd0);
    #1;
    rst = 1'b0;

    // Fill with decode stalled
    clear_logs();
    repeat (6) step(1'b0, 1'b0, 32'h0);
    chk("fill_nreq", 32'(rlog.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("fill_addr", rl(i), 32'(i));
    chk("fill_occ", obs_occ, 32'd4);
    chk("fill_req_off", 32'(obs_req), 32'd0);
    chk("fill_next_addr", obs_addr, 32'd4);
    step(1'b0, 1'b0, 32'h0);
    chk("full_hold_req", 32'(obs_req), 32'd0);

    // Drain; fetch resumes at word 4 without gaps
    clear_logs();
    repeat (8) step(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      chk("drain_inst", dl_inst(i), 32'(i));
      chk("drain_pc4", dl_pc4(i), 32'(4 * i + 4));
      chk("drain_addr", rl(i), 32'(4 + i));
    end

    // Streaming from reset
    pulse_reset(pre);
    clear_logs();
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b0, 32'h0);
      chk("stream_valid", 32'(obs_valid), (k >= 2) ? 32'd1 : 32'd0);
      chk("stream_occ_le1", 32'(obs_occ <= 32'd1), 32'd1);
    end
    chk("stream_count", 32'(dlog.size()), 32'd8);
    for (int i = 0; i < 8; i++) chk("stream_pc4", dl_pc4(i), 32'(4 * i + 4));

    // Redirect with a read in flight and two entries queued
    pulse_reset(pre);
    repeat (3) step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h20);
    chk("redir_occ_before", obs_occ, 32'd2);
    chk("redir_valid", 32'(obs_valid), 32'd0);
    clear_logs();
    repeat (4) step(1'b1, 1'b0, 32'h0);
    chk("redir_first_addr", rl(0), 32'd8);
    chk("redir_first_inst", dl_inst(0), 32'd8);
    chk("redir_first_pc4", dl_pc4(0), 32'h24);
    chk("redir_ndeliv", 32'(dlog.size()), 32'd2);

    // Misaligned redirect concurrent with ready and three entries queued
    pulse_reset(pre);
    repeat (4) step(1'b0, 1'b0, 32'h0);
    clear_logs();
    step(1'b1, 1'b1, 32'h33);
    chk("mis_occ_before", obs_occ, 32'd3);
    chk("mis_no_transfer", 32'(dlog.size()), 32'd0);
    clear_logs();
    repeat (4) step(1'b1, 1'b0, 32'h0);
    chk("mis_first_addr", rl(0), 32'd12);
    chk("mis_first_pc4", dl_pc4(0), 32'h34);

    // Back-to-back redirects: last one wins
    step(1'b1, 1'b1, 32'h40);
    step(1'b1, 1'b1, 32'h80);
    clear_logs();
    repeat (4) step(1'b1, 1'b0, 32'h0);
    chk("b2b_first_addr", rl(0), 32'd32);
    chk("b2b_first_pc4", dl_pc4(0), 32'h84);

    // Fetch PC wraps through 2^32
    step(1'b1, 1'b1, 32'hFFFF_FFFC);
    clear_logs();
    repeat (5) step(1'b1, 1'b0, 32'h0);
    chk("wrap_addr0", rl(0), 32'd63);
    chk("wrap_addr1", rl(1), 32'd0);
    chk("wrap_inst0", dl_inst(0), 32'd63);
    chk("wrap_pc4_0", dl_pc4(0), 32'h0);
    chk("wrap_pc4_1", dl_pc4(1), 32'h4);

    // Async reset mid-stream with three entries queued
    pulse_reset(pre);
    repeat (4) step(1'b0, 1'b0, 32'h0);
    pulse_reset(pre);
    chk("midrst_occ_before", pre, 32'd3);
    clear_logs();
    repeat (4) step(1'b1, 1'b0, 32'h0);
    chk("midrst_first_addr", rl(0), 32'd0);
    chk("midrst_first_inst", dl_inst(0), 32'd0);
    chk("midrst_first_pc4", dl_pc4(0), 32'h4);

    // Irregular decode stalls with a redirect mid-stream
    pat = 32'hB2D4_6F19;
    for (int i = 0; i < 32; i++) begin
      if (i == 20) step(pat[i], 1'b1, 32'h100);
      else         step(pat[i], 1'b0, 32'h0);
    end
    repeat (6) step(1'b1, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
